// File: rtl/header_word_server_pkg.sv
// Shared constants and helpers for the block-header word store and its fetch bus.
package header_word_server_pkg;

  localparam int HDR_BYTES    = 80;
  localparam int HDR_WORDS    = HDR_BYTES / 4;
  localparam int NONCE_WORD   = 19;
  localparam int FETCH_ADDR_W = 5;
  localparam int BLK2_BASE    = 16;
  localparam int PTR_W        = 7;
  localparam int WORD_IDX_W   = PTR_W - 2;

  typedef logic [31:0] word_t;

  // Wire order is big-endian: byte 0 of a word lands in bits [31:24].
  function automatic logic [1:0] byte_lane(input logic [PTR_W-1:0] ptr);
    return ~ptr[1:0];
  endfunction

endpackage

// File: rtl/header_word_server_if.sv
// Word-fetch bus between the SHA-256d initiator (master) and the header store (slave).
interface header_word_server_if;
  import header_word_server_pkg::*;

  logic                    rq;
  logic [FETCH_ADDR_W-1:0] addr;
  logic                    rdy;
  word_t                   data;

  modport master (output rq, addr, input rdy, data);
  modport slave  (input rq, addr, output rdy, data);

endinterface

// File: rtl/header_word_server.sv
// Holds one 80-byte block header loaded byte-serially by the host and serves its
// 32-bit words to the hasher with a one-cycle registered read.
module header_word_server
  import header_word_server_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_valid,
  input  logic [7:0]           load_byte,
  output logic                 load_ready,
  input  logic                 load_restart,
  input  logic                 lock,
  input  logic                 nonce_inc,
  header_word_server_if.slave  bus,
  output logic                 header_valid,
  output word_t                nonce
);

  logic [HDR_WORDS-1:0][31:0] words;
  logic [PTR_W-1:0]           ptr_reg, ptr_next;
  logic                       header_valid_reg, header_valid_next;
  word_t                      data_reg, data_next;
  logic                       hit_reg;
  logic [FETCH_ADDR_W-1:0]    addr_reg;
  logic                       accept;
  logic                       byte_wr;
  logic [WORD_IDX_W-1:0]      wr_word;
  logic [1:0]                 wr_lane;

  assign load_ready = !lock && rst_n;
  assign accept     = load_valid && load_ready;
  assign byte_wr    = accept && !load_restart;
  assign wr_word    = ptr_reg[PTR_W-1:2];
  assign wr_lane    = byte_lane(ptr_reg);

  always_comb begin
    ptr_next          = ptr_reg;
    header_valid_next = header_valid_reg;
    if (load_restart) begin
      ptr_next          = '0;
      header_valid_next = 1'b0;
    end else if (accept) begin
      if (ptr_reg == PTR_W'(HDR_BYTES - 1)) begin
        ptr_next          = '0;
        header_valid_next = 1'b1;
      end else begin
        ptr_next = ptr_reg + PTR_W'(1);
        if (ptr_reg == '0) header_valid_next = 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < HDR_WORDS; gi++) begin : g_word
      word_t word_reg, word_next;

      // A host byte landing in the nonce word beats a same-cycle increment.
      always_comb begin
        word_next = word_reg;
        if (byte_wr && (wr_word == WORD_IDX_W'(gi))) begin
          word_next[{wr_lane, 3'b000} +: 8] = load_byte;
        end else if ((gi == NONCE_WORD) && nonce_inc) begin
          word_next = word_reg + 32'd1;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) word_reg <= '0;
        else        word_reg <= word_next;
      end

      assign words[gi] = word_reg;
    end
  endgenerate

  always_comb begin
    data_next = '0;
    for (int i = 0; i < HDR_WORDS; i++) begin
      if (bus.addr == FETCH_ADDR_W'(i)) data_next = words[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_reg          <= '0;
      header_valid_reg <= 1'b0;
      data_reg         <= '0;
      hit_reg          <= 1'b0;
      addr_reg         <= '0;
    end else begin
      ptr_reg          <= ptr_next;
      header_valid_reg <= header_valid_next;
      data_reg         <= data_next;
      hit_reg          <= bus.rq;
      addr_reg         <= bus.addr;
    end
  end

  // Ready only once the registered read matches the address still being requested.
  assign bus.rdy      = bus.rq && hit_reg && (addr_reg == bus.addr);
  assign bus.data     = data_reg;
  assign header_valid = header_valid_reg;
  assign nonce        = words[NONCE_WORD];

endmodule
